// File: rtl/exe_muldiv_unit.sv
// Iterative EXE-stage multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, with HI/LO result registers and a start/busy/done handshake.
module exe_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EXE_Start,
    input  logic [1:0]       EXE_MDOp,
    input  logic [WIDTH-1:0] EXE_ResultA,
    input  logic [WIDTH-1:0] EXE_ResultB,
    input  logic             EXE_Flush,
    output logic             EXE_MDBusy,
    output logic             EXE_MDDone,
    output logic             EXE_DivZero,
    output logic [WIDTH-1:0] EXE_Hi,
    output logic [WIDTH-1:0] EXE_Lo
);

    // Handshake: EXE_Start is taken only in IDLE without EXE_Flush; EXE_MDBusy
    // stays high until the unit is back in IDLE; EXE_MDDone is a one-cycle pulse
    // in the cycle HI/LO first hold the new result.
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               divzero_q, divzero_d;

    logic               in_signed, in_div, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_trial, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_next, div_next, step_next, prod_fix;
    logic [WIDTH-1:0]   quot, rem, fix_hi, fix_lo;

    always_comb begin
        in_signed = ~EXE_MDOp[0];
        in_div    = EXE_MDOp[1];
        a_neg     = in_signed & EXE_ResultA[WIDTH-1];
        b_neg     = in_signed & EXE_ResultB[WIDTH-1];
        a_mag     = a_neg ? -EXE_ResultA : EXE_ResultA;
        b_mag     = b_neg ? -EXE_ResultB : EXE_ResultB;

        // Multiply: acc = {partial product, remaining multiplier bits}.
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

        // Divide: acc = {partial remainder, dividend bits shifting into quotient}.
        div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_trial - {1'b0, opnd_q};
        div_ge    = ~div_diff[WIDTH];
        div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};

        step_next = op_q[1] ? div_next : mul_next;

        prod_fix  = neg_res_q ? -step_next : step_next;
        quot      = step_next[WIDTH-1:0];
        rem       = step_next[2*WIDTH-1:WIDTH];
        fix_lo    = op_q[1] ? (neg_res_q ? -quot : quot) : prod_fix[WIDTH-1:0];
        fix_hi    = op_q[1] ? (neg_rem_q ? -rem : rem) : prod_fix[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        divzero_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (EXE_Start && !EXE_Flush) begin
                    op_d      = EXE_MDOp;
                    cnt_d     = '0;
                    neg_res_d = in_signed & (EXE_ResultA[WIDTH-1] ^ EXE_ResultB[WIDTH-1]);
                    neg_rem_d = a_neg;
                    if (in_div && (EXE_ResultB == '0)) begin
                        state_d   = S_DONE;
                        hi_d      = EXE_ResultA;
                        lo_d      = '1;
                        divzero_d = 1'b1;
                    end else if (in_div) begin
                        state_d = S_CALC;
                        acc_d   = {{WIDTH{1'b0}}, a_mag};
                        opnd_d  = b_mag;
                    end else begin
                        state_d = S_CALC;
                        acc_d   = {{WIDTH{1'b0}}, b_mag};
                        opnd_d  = a_mag;
                    end
                end
            end
            S_CALC: begin
                if (EXE_Flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = step_next;
                    cnt_d = cnt_q + 1'b1;
                    // The last step and the sign fix-up land together on the DONE edge.
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = S_DONE;
                        hi_d    = fix_hi;
                        lo_d    = fix_lo;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            divzero_q <= divzero_d;
        end
    end

    assign EXE_MDBusy  = (state_q != S_IDLE);
    assign EXE_MDDone  = (state_q == S_DONE);
    assign EXE_DivZero = divzero_q;
    assign EXE_Hi      = hi_q;
    assign EXE_Lo      = lo_q;

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Directed bench for exe_muldiv_unit: a vector table of full operations plus
// hand-written flush, mid-op start and asynchronous reset sequences.
module tb_exe_muldiv_unit;
    localparam int W = 32;

    logic         clk, rst;
    logic         EXE_Start, EXE_Flush;
    logic [1:0]   EXE_MDOp;
    logic [W-1:0] EXE_ResultA, EXE_ResultB;
    logic         EXE_MDBusy, EXE_MDDone, EXE_DivZero;
    logic [W-1:0] EXE_Hi, EXE_Lo;

    exe_muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .EXE_Start(EXE_Start), .EXE_MDOp(EXE_MDOp),
        .EXE_ResultA(EXE_ResultA), .EXE_ResultB(EXE_ResultB),
        .EXE_Flush(EXE_Flush),
        .EXE_MDBusy(EXE_MDBusy), .EXE_MDDone(EXE_MDDone), .EXE_DivZero(EXE_DivZero),
        .EXE_Hi(EXE_Hi), .EXE_Lo(EXE_Lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           cyc;
    } vec_t;

    vec_t vecs[11];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op at edge 0, then watch cycles 1..40.
    task automatic run_vec(input string name, input vec_t v);
        int   done_cyc, done_cnt;
        logic busy_ok, stray_dz, dz_at_done;
        logic [W-1:0] hi_at_done, lo_at_done;
        done_cyc = -1; done_cnt = 0; busy_ok = 1'b1; stray_dz = 1'b0;
        dz_at_done = 1'b0; hi_at_done = '0; lo_at_done = '0;
        EXE_MDOp = v.op; EXE_ResultA = v.a; EXE_ResultB = v.b; EXE_Start = 1'b1;
        step();
        EXE_Start = 1'b0;
        EXE_MDOp = 2'($urandom_range(0, 3));
        EXE_ResultA = $urandom;
        EXE_ResultB = $urandom;
        for (int c = 1; c <= 40; c++) begin
            if (EXE_MDBusy !== (c <= v.cyc)) busy_ok = 1'b0;
            if (EXE_DivZero && !EXE_MDDone) stray_dz = 1'b1;
            if (EXE_MDDone) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    hi_at_done = EXE_Hi;
                    lo_at_done = EXE_Lo;
                    dz_at_done = EXE_DivZero;
                end
            end
            step();
        end
        check({name, "_done_cycle"}, 64'(done_cyc), 64'(v.cyc));
        check({name, "_done_count"}, 64'(done_cnt), 64'd1);
        check({name, "_busy_window"}, 64'(busy_ok), 64'd1);
        check({name, "_stray_divzero"}, 64'(stray_dz), 64'd0);
        check({name, "_hi"}, 64'(hi_at_done), 64'(v.hi));
        check({name, "_lo"}, 64'(lo_at_done), 64'(v.lo));
        check({name, "_divzero"}, 64'(dz_at_done), 64'(v.dz));
    endtask

    initial begin
        int   done_seen;
        logic busy_seen;

        vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
        vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
        vecs[3]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
        vecs[4]  = '{2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1, 1};
        vecs[5]  = '{2'b01, 32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A, 1'b0, 33};
        vecs[6]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
        vecs[7]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33};
        vecs[8]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33};
        vecs[9]  = '{2'b10, 32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1};
        vecs[10] = '{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, 33};

        rst = 1'b1; EXE_Start = 1'b0; EXE_Flush = 1'b0; EXE_MDOp = 2'b00;
        EXE_ResultA = '0; EXE_ResultB = '0;
        #12;
        check("reset_busy", 64'(EXE_MDBusy), 64'd0);
        check("reset_done", 64'(EXE_MDDone), 64'd0);
        check("reset_divzero", 64'(EXE_DivZero), 64'd0);
        check("reset_hi", 64'(EXE_Hi), 64'd0);
        check("reset_lo", 64'(EXE_Lo), 64'd0);
        #8 rst = 1'b0;
        step();

        for (int i = 0; i < 11; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Flush in cycle 10 of MULTU 6*7, with a stray Start in cycle 5.
        EXE_MDOp = 2'b01; EXE_ResultA = 32'd6; EXE_ResultB = 32'd7; EXE_Start = 1'b1;
        step();
        EXE_Start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            EXE_Start = (c == 5);
            EXE_ResultA = 32'd2; EXE_ResultB = 32'd3;
            step();
        end
        EXE_Start = 1'b0;
        check("flush_busy_before", 64'(EXE_MDBusy), 64'd1);
        EXE_Flush = 1'b1;
        step();
        check("flush_busy_after", 64'(EXE_MDBusy), 64'd0);
        check("flush_no_done", 64'(EXE_MDDone), 64'd0);
        // Start together with Flush while idle must be ignored.
        EXE_Start = 1'b1;
        step();
        EXE_Start = 1'b0; EXE_Flush = 1'b0;
        done_seen = 0; busy_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (EXE_MDDone) done_seen++;
            if (EXE_MDBusy) busy_seen = 1'b1;
            step();
        end
        check("flush_quiet_done", 64'(done_seen), 64'd0);
        check("flush_quiet_busy", 64'(busy_seen), 64'd0);
        check("flush_hi_kept", 64'(EXE_Hi), 64'h2);
        check("flush_lo_kept", 64'(EXE_Lo), 64'hE);

        run_vec("restart", vecs[5]);

        // Flush sampled on the edge that would enter DONE: HI/LO must not change.
        EXE_MDOp = 2'b01; EXE_ResultA = '1; EXE_ResultB = '1; EXE_Start = 1'b1;
        step();
        EXE_Start = 1'b0;
        for (int c = 1; c < 32; c++) step();
        check("lateflush_busy_before", 64'(EXE_MDBusy), 64'd1);
        EXE_Flush = 1'b1;
        step();
        EXE_Flush = 1'b0;
        check("lateflush_busy", 64'(EXE_MDBusy), 64'd0);
        check("lateflush_done", 64'(EXE_MDDone), 64'd0);
        check("lateflush_hi", 64'(EXE_Hi), 64'h0);
        check("lateflush_lo", 64'(EXE_Lo), 64'h2A);

        // Asynchronous reset in cycle 15 of a DIV.
        EXE_MDOp = 2'b10; EXE_ResultA = 32'd1000; EXE_ResultB = 32'd3; EXE_Start = 1'b1;
        step();
        EXE_Start = 1'b0;
        for (int c = 1; c < 15; c++) step();
        check("areset_busy_before", 64'(EXE_MDBusy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("areset_busy", 64'(EXE_MDBusy), 64'd0);
        check("areset_done", 64'(EXE_MDDone), 64'd0);
        check("areset_divzero", 64'(EXE_DivZero), 64'd0);
        check("areset_hi", 64'(EXE_Hi), 64'd0);
        check("areset_lo", 64'(EXE_Lo), 64'd0);
        #2 rst = 1'b0;
        step();
        run_vec("post_reset_divu", '{2'b11, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 33});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
